// File: rtl/matvec_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the matrix-vector sequencer: defaults, header layout, FSM states.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package matvec_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_ELEMS = 1022;

  // Matrix memory layout: two header words, then column-major elements.
  localparam int HDR_ROWS  = 0;
  localparam int HDR_COLS  = 1;
  localparam int DATA_BASE = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_CHECK,
    S_ROW_INIT,
    S_RD,
    S_MAC,
    S_WR,
    S_FIN
  } state_t;

endpackage

// File: rtl/matvec_mac.sv
`timescale 1ns/1ps
// Signed multiply-accumulate with synchronous clear; product and sum wrap at DATA_W bits.
// Latency: o_sum is combinational from the stored accumulator, the update lands next edge.
// Backpressure: none; i_en qualifies each accumulate step.
module matvec_mac #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // Low DATA_W bits of the signed product; the upper half is discarded by design.
  always_comb begin
    w_prod = DATA_W'($signed(i_a) * $signed(i_b));
    o_sum  = r_acc + w_prod;
  end

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
`timescale 1ns/1ps
// Sequencer computing y = M*v from a column-major matrix memory with a rows/cols header.
// Latency: 3 header cycles plus 2*cols+2 cycles per row; one result write per row.
// Backpressure: none; memories answer in one cycle and start is ignored while a job runs.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_ELEMS = DEF_MAX_ELEMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       clock_count,
  output logic [ADDR_W-1:0] mat_addr,
  input  logic [DATA_W-1:0] mat_rdata,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_rdata,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_wdata
);

  localparam logic signed [DATA_W-1:0]   LP_ZERO     = '0;
  localparam logic signed [DATA_W-1:0]   LP_DIM_MAX  = DATA_W'(64'd1 << ADDR_W);
  localparam logic signed [2*DATA_W-1:0] LP_ELEM_MAX = (2*DATA_W)'(MAX_ELEMS);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [31:0]        r_clock_count;
  logic [ADDR_W-1:0]  r_mat_addr;
  logic [ADDR_W-1:0]  r_vec_addr;
  logic               r_res_we;
  logic [ADDR_W-1:0]  r_res_addr;
  logic [DATA_W-1:0]  r_res_wdata;

  // Job context: captured header, loop indices and the running column offset j*rows.
  logic [DATA_W-1:0]  r_rows;
  logic [ADDR_W-1:0]  r_stride;
  logic [ADDR_W-1:0]  r_row_last;
  logic [ADDR_W-1:0]  r_col_last;
  logic [ADDR_W-1:0]  r_i;
  logic [ADDR_W-1:0]  r_j;
  logic [ADDR_W-1:0]  r_col_base;

  logic signed [DATA_W-1:0]   w_rows_s;
  logic signed [DATA_W-1:0]   w_cols_s;
  logic signed [2*DATA_W-1:0] w_area;
  logic                       w_hdr_bad;
  logic [ADDR_W-1:0]          w_next_base;
  logic                       w_mac_clr;
  logic                       w_mac_en;
  logic [DATA_W-1:0]          w_mac_sum;

  // Header validation: cols is live on mat_rdata during CHECK, rows was captured in HDR1.
  always_comb begin
    w_rows_s  = $signed(r_rows);
    w_cols_s  = $signed(mat_rdata);
    w_area    = (2*DATA_W)'(w_rows_s) * (2*DATA_W)'(w_cols_s);
    w_hdr_bad = (w_rows_s <= LP_ZERO) || (w_cols_s <= LP_ZERO) ||
                (w_rows_s > LP_DIM_MAX) || (w_cols_s > LP_DIM_MAX) ||
                (w_area > LP_ELEM_MAX);
  end

  // Datapath controls; the column offset advances by rows each column instead of multiplying.
  always_comb begin
    w_next_base = r_col_base + r_stride;
    w_mac_clr   = (r_state == S_ROW_INIT);
    w_mac_en    = (r_state == S_MAC);
  end

  matvec_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_a    (mat_rdata),
    .i_b    (vec_rdata),
    .o_sum  (w_mac_sum)
  );

  // Control FSM with registered outputs; read addresses are loaded on entry to the state that presents them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_clock_count <= '0;
      r_mat_addr    <= '0;
      r_vec_addr    <= '0;
      r_res_we      <= 1'b0;
      r_res_addr    <= '0;
      r_res_wdata   <= '0;
      r_rows        <= '0;
      r_stride      <= '0;
      r_row_last    <= '0;
      r_col_last    <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_col_base    <= '0;
    end else begin
      r_res_we <= 1'b0;
      if (r_busy && (r_clock_count != '1)) begin
        r_clock_count <= r_clock_count + 32'd1;
      end

      case (r_state)
        S_IDLE, S_FIN: begin
          if (start) begin
            r_state       <= S_HDR0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_clock_count <= '0;
            r_mat_addr    <= ADDR_W'(HDR_ROWS);
          end
        end

        S_HDR0: begin
          r_mat_addr <= ADDR_W'(HDR_COLS);
          r_state    <= S_HDR1;
        end

        S_HDR1: begin
          r_rows  <= mat_rdata;
          r_state <= S_CHECK;
        end

        S_CHECK: begin
          if (w_hdr_bad) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_stride   <= r_rows[ADDR_W-1:0];
            r_row_last <= ADDR_W'(r_rows - DATA_W'(1));
            r_col_last <= ADDR_W'(mat_rdata - DATA_W'(1));
            r_i        <= '0;
            r_state    <= S_ROW_INIT;
          end
        end

        S_ROW_INIT: begin
          r_j        <= '0;
          r_col_base <= '0;
          r_mat_addr <= ADDR_W'(DATA_BASE) + r_i;
          r_vec_addr <= '0;
          r_state    <= S_RD;
        end

        S_RD: begin
          r_state <= S_MAC;
        end

        S_MAC: begin
          r_j <= r_j + 1'b1;
          if (r_j == r_col_last) begin
            r_res_we    <= 1'b1;
            r_res_addr  <= r_i;
            r_res_wdata <= w_mac_sum;
            r_state     <= S_WR;
          end else begin
            r_col_base <= w_next_base;
            r_mat_addr <= ADDR_W'(DATA_BASE) + r_i + w_next_base;
            r_vec_addr <= r_j + 1'b1;
            r_state    <= S_RD;
          end
        end

        S_WR: begin
          if (r_i == r_row_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_i     <= r_i + 1'b1;
            r_state <= S_ROW_INIT;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign clock_count = r_clock_count;
  assign mat_addr    = r_mat_addr;
  assign vec_addr    = r_vec_addr;
  assign res_we      = r_res_we;
  assign res_addr    = r_res_addr;
  assign res_wdata   = r_res_wdata;

endmodule

// File: tb/tb_matvec_sequencer.sv
`timescale 1ns/1ps
// Bench for matvec_sequencer: directed and random jobs, scoreboard-checked results.
// Latency: expectations are queued per job and consumed as writes and done edges appear.
// Backpressure: none; memories are modelled as one-cycle synchronous reads.
module tb_matvec_sequencer;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err, res_we;
  logic [31:0]   clock_count;
  logic [AW-1:0] mat_addr, vec_addr, res_addr;
  logic [DW-1:0] mat_rdata, vec_rdata, res_wdata;

  logic [DW-1:0] mat_mem [0:DEPTH-1];
  logic [DW-1:0] vec_mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  bit          exp_err_q[$];
  int          exp_cnt_q[$];

  logic        done_q = 1'b0;
  int          mon_ea;
  logic [31:0] mon_ed;
  bit          mon_ee;
  int          mon_ec;

  matvec_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .clock_count (clock_count),
    .mat_addr    (mat_addr),
    .mat_rdata   (mat_rdata),
    .vec_addr    (vec_addr),
    .vec_rdata   (vec_rdata),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_wdata   (res_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    mat_rdata <= mat_mem[mat_addr];
    vec_rdata <= vec_mem[vec_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: y[i] = sum_j M(i,j)*v[j] mod 2^32, straight from the memory layout.
  task automatic push_expect(input int rows, input int cols, input int row_limit, input bit with_fin);
    longint area;
    bit     bad;
    longint acc;
    area = longint'(rows) * longint'(cols);
    bad  = (rows <= 0) || (cols <= 0) || (rows > DEPTH) || (cols > DEPTH) || (area > 1022);
    if (!bad) begin
      for (int i = 0; i < rows && i < row_limit; i++) begin
        acc = 0;
        for (int j = 0; j < cols; j++) begin
          acc += longint'($signed(mat_mem[2 + i + j*rows])) * longint'($signed(vec_mem[j]));
        end
        exp_wa.push_back(i);
        exp_wd.push_back(32'(acc));
      end
    end
    if (with_fin) begin
      exp_err_q.push_back(bad);
      exp_cnt_q.push_back(bad ? 3 : 3 + rows*(2*cols + 2));
    end
  endtask

  // Monitor: compares every result write and every completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_we) begin
        if (exp_wa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, no write required", res_addr, res_wdata);
        end else begin
          mon_ea = exp_wa.pop_front();
          mon_ed = exp_wd.pop_front();
          check("res_addr", 64'(res_addr), 64'(mon_ea));
          check("res_wdata", 64'(res_wdata), 64'(mon_ed));
        end
      end
      if (done && !done_q) begin
        if (exp_cnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done rose with no job pending");
        end else begin
          mon_ee = exp_err_q.pop_front();
          mon_ec = exp_cnt_q.pop_front();
          check("fin_err", 64'(err), 64'(mon_ee));
          check("fin_clock_count", 64'(clock_count), 64'(mon_ec));
          check("fin_busy", 64'(busy), 64'd0);
          check("fin_writes_left", 64'(exp_wa.size()), 64'd0);
        end
      end
    end
    done_q = done;
  end

  task automatic fill_random(input int mode);
    for (int k = 2; k < DEPTH; k++) begin
      mat_mem[k] = (mode == 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
    end
    for (int k = 0; k < DEPTH; k++) begin
      vec_mem[k] = (mode == 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
    end
  endtask

  task automatic set_el(input int rows, input int i, input int j, input int val);
    mat_mem[2 + i + j*rows] = 32'(val);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_done", 64'(done), 64'd0);
    check("start_sets_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_within_budget", 64'(seen), 64'd1);
    @(posedge clk);
  endtask

  // extra_at > 0 pulses start again that many cycles into the job; it must be ignored.
  task automatic run_job(input int rows, input int cols, input int extra_at);
    mat_mem[0] = 32'(rows);
    mat_mem[1] = 32'(cols);
    push_expect(rows, cols, rows, 1'b1);
    pulse_start();
    if (extra_at > 0) begin
      repeat (extra_at) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(6000);
  endtask

  task automatic load_2x2();
    mat_mem[2] = 32'd1; mat_mem[3] = 32'd3; mat_mem[4] = 32'd2; mat_mem[5] = 32'd4;
    vec_mem[0] = 32'd5; vec_mem[1] = 32'd6;
  endtask

  initial begin
    fill_random(1);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(clock_count), 64'd0);
    check("rst_res_we", 64'(res_we), 64'd0);
    check("rst_mat_addr", 64'(mat_addr), 64'd0);
    rst = 1'b0;

    // 2x2 basic: y = [17, 39], 15 cycles
    load_2x2();
    run_job(2, 2, 0);

    // 3x4 with negative entries and a zero row
    begin
      int m34 [0:2][0:3];
      m34 = '{'{-1, 2, -3, 4}, '{0, 0, 0, 0}, '{7, -7, 7, -7}};
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++)
          set_el(3, i, j, m34[i][j]);
      for (int j = 0; j < 4; j++) vec_mem[j] = 32'd1;
      run_job(3, 4, 0);
    end

    // zero rows: error, no writes, 3 cycles
    run_job(0, 5, 0);

    // product overflow wraps to zero
    mat_mem[2] = 32'h4000_0000; mat_mem[3] = 32'h4000_0000;
    vec_mem[0] = 32'd4; vec_mem[1] = 32'd4;
    run_job(1, 2, 0);

    // start pulses while busy are ignored
    load_2x2();
    run_job(2, 2, 3);
    run_job(2, 2, 9);

    // reset during MAC of row 1 in a 3x3 job
    fill_random(1);
    mat_mem[0] = 32'd3;
    mat_mem[1] = 32'd3;
    push_expect(3, 3, 1, 1'b0);
    pulse_start();
    begin
      bit seen_wr;
      seen_wr = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (res_we) begin
          seen_wr = 1'b1;
          break;
        end
      end
      check("row0_write_seen", 64'(seen_wr), 64'd1);
    end
    repeat (3) @(negedge clk);
    check("row1_mac_mat_addr", 64'(mat_addr), 64'd3);
    check("row1_mac_vec_addr", 64'(vec_addr), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_res_we", 64'(res_we), 64'd0);
    check("midrst_count", 64'(clock_count), 64'd0);
    check("midrst_mat_addr", 64'(mat_addr), 64'd0);
    check("midrst_vec_addr", 64'(vec_addr), 64'd0);
    check("midrst_res_addr", 64'(res_addr), 64'd0);
    check("midrst_res_wdata", 64'(res_wdata), 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("midrst_writes_left", 64'(exp_wa.size()), 64'd0);
    load_2x2();
    run_job(2, 2, 0);

    // randomized valid jobs
    for (int n = 0; n < 12; n++) begin
      fill_random(n % 2);
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0);
    end

    // invalid headers
    run_job(-1, 4, 0);
    run_job(4, -2, 0);
    run_job(1025, 1, 0);
    run_job(1, 1025, 0);
    run_job(32, 32, 0);
    run_job(1023, 1, 0);
    run_job(0, 0, 0);

    // largest legal shapes
    fill_random(0);
    run_job(1022, 1, 0);
    run_job(1, 1022, 0);
    run_job(2, 511, 0);

    check("final_writes_left", 64'(exp_wa.size()), 64'd0);
    check("final_fins_left", 64'(exp_cnt_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
Hardware controller that runs a dense signed matrix-vector product y = M·v against the matrix, vector and result memories.
- Matrix memory is column-major, with a two-word header: word 0 = rows, word 1 = cols, element (i,j) at address 2 + i + j*rows.
- The block reads the header, validates it, walks every row, accumulates products and writes y[i] to the result memory.
- Exposes done/clock_count status in the same form the CPU top level reports, so benches compare software and hardware runs directly.

Parameters:
- ADDR_W, 10, address width of all three memories (depth 2^ADDR_W words).
- DATA_W, 32, data width; all operands signed two's complement.
- MAX_ELEMS, 1022, maximum rows*cols (memory depth minus the two header words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE or FIN.
- busy  out  1  high from the cycle after an accepted start until the job finishes.
- done  out  1  level; set on completion, cleared when the next start is accepted.
- err  out  1  level; set with done when the header is invalid, cleared on the next accepted start.
- clock_count  out  32  cycles spent with busy high in the last or current job.
- mat_addr  out  ADDR_W  matrix memory read address.
- mat_rdata  in  DATA_W  matrix read data, valid one cycle after mat_addr.
- vec_addr  out  ADDR_W  vector memory read address.
- vec_rdata  in  DATA_W  vector read data, valid one cycle after vec_addr.
- res_we  out  1  result write strobe.
- res_addr  out  ADDR_W  result write address (row index i).
- res_wdata  out  DATA_W  result value y[i].

Behaviour:
- Reset: asynchronous. State IDLE; busy, done, err, res_we = 0; clock_count = 0; all addresses and res_wdata = 0; internal i, j, acc = 0. Reset mid-job abandons the job with no further writes.
- FSM states: IDLE, HDR0, HDR1, CHECK, ROW_INIT, RD, MAC, WR, FIN.
- IDLE/FIN + start → HDR0. On acceptance: clear done and err, set clock_count = 0. start is ignored in every other state.
- HDR0: mat_addr = 0.
- HDR1: mat_addr = 1; capture rows from mat_rdata.
- CHECK: capture cols. If rows ≤ 0, cols ≤ 0, rows > 2^ADDR_W, cols > 2^ADDR_W, or rows*cols > MAX_ELEMS (rows*cols computed at 2*DATA_W width): set err → FIN. Otherwise i = 0 → ROW_INIT.
- ROW_INIT: acc = 0, j = 0 → RD.
- RD: mat_addr = 2 + i + j*rows; vec_addr = j → MAC.
- MAC: acc = acc + (mat_rdata*vec_rdata)[DATA_W-1:0]; j++. If j == cols-1 → WR, else → RD.
- WR: res_we = 1 for exactly this cycle; res_addr = i; res_wdata = acc. If i == rows-1 → FIN, else i++ → ROW_INIT.
- FIN: busy = 0, done = 1; hold until the next start.
- Arithmetic: product truncated to DATA_W bits; accumulator wraps mod 2^DATA_W; no saturation; no overflow flag.
- Timing: busy is high exactly in HDR0..WR. clock_count increments on every busy cycle and saturates at 2^32-1.
- Valid job: clock_count = 3 + rows*(2*cols+2). Error job: clock_count = 3.
- Result writes occur only in WR, in ascending i, one write per row.
- done rises the cycle after the last WR, or the cycle after CHECK on error.
- mat_addr and vec_addr hold their last value outside RD, HDR0 and HDR1.

Decomposition:
- Shared package matvec_pkg: state enum, ADDR_W/DATA_W/MAX_ELEMS defaults, header offset constants HDR_ROWS=0, HDR_COLS=1, DATA_BASE=2.
- One sub-module, matvec_mac: registered accumulator with clear, enable and truncating signed multiply-add, instantiated once by the FSM.

Test Plan:
- 2x2, M=[[1,2],[3,4]] stored as 2,2,1,3,2,4; v=[5,6] → writes y[0]=17, y[1]=39; done=1, err=0, clock_count=15.
- 3x4 with negative entries, M row0=[-1,2,-3,4], row1=[0,0,0,0], row2=[7,-7,7,-7]; v=[1,1,1,1] → y=[2,0,0], exactly 3 res_we pulses, clock_count=33.
- Header rows=0, cols=5 → err=1, done=1, zero res_we pulses, clock_count=3.
- Overflow: 1x2 with M=[0x40000000, 0x40000000], v=[4,4] → y[0]=0 (wrapped); err=0.
- start pulsed while busy in a 2x2 job → ignored; results and clock_count identical to the first test. A second start in FIN clears done within one cycle.
- rst asserted during MAC of row 1 in a 3x3 job → all outputs 0 immediately, no further writes. A fresh start afterwards completes normally.
